// File: rtl/encrypt_job_sched_if.sv
// Requester/engine side bundle of the encrypt job scheduler.
// master: the requesters plus the engine status pins; slave: the scheduler.
interface encrypt_job_sched_if #(
    parameter int unsigned NREQ = 4
);
    logic            enable;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done_pulse;
    logic [NREQ-1:0] err_pulse;
    logic [1:0]      enc_start;
    logic [2:0]      enc_stop;
    logic            busy;
    logic            timeout_err;
    logic            err_clr;
    logic [15:0]     jobs_done;

    modport master (
        output enable,
        output req,
        output enc_stop,
        output err_clr,
        input  grant,
        input  done_pulse,
        input  err_pulse,
        input  enc_start,
        input  busy,
        input  timeout_err,
        input  jobs_done
    );

    modport slave (
        input  enable,
        input  req,
        input  enc_stop,
        input  err_clr,
        output grant,
        output done_pulse,
        output err_pulse,
        output enc_start,
        output busy,
        output timeout_err,
        output jobs_done
    );
endinterface

// File: rtl/encrypt_job_sched.sv
// Round-robin scheduler sharing one encrypt engine among NREQ requesters.
// Runs the engine start/ack/done handshake and guards each job with a watchdog.
module encrypt_job_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 8
) (
    input logic                clk,
    input logic                reset,
    encrypt_job_sched_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0] ENC_ACK  = 3'b001;
    localparam logic [2:0] ENC_DONE = 3'b010;
    localparam logic [1:0] ENC_GO   = 2'b01;
    localparam logic [1:0] ENC_IDLE = 2'b00;

    typedef enum logic [1:0] {StIdle, StStart, StRun, StErr} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [1:0]      enc_start_q, enc_start_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;
    logic [15:0]     jobs_q, jobs_d;
    logic [TW-1:0]   wdog_q, wdog_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;

    // Round-robin pick: first requester after rr_q, wrapping, rr_q itself last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = PW'((32'(rr_q) + i) % NREQ);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = '0;
        enc_start_d = enc_start_q;
        terr_d      = terr_q;
        jobs_d      = jobs_q;
        wdog_d      = wdog_q;
        rr_d        = rr_q;
        owner_d     = owner_q;

        unique case (state_q)
            StIdle: begin
                if (bus.enable && win_valid) begin
                    state_d          = StStart;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    enc_start_d      = ENC_GO;
                    wdog_d           = '0;
                end
            end
            StStart: begin
                wdog_d = wdog_q + 1'b1;
                // Only an explicit ack counts; stale done status from the last job is ignored.
                if (bus.enc_stop == ENC_ACK) begin
                    state_d     = StRun;
                    enc_start_d = ENC_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d         = StErr;
                    enc_start_d     = ENC_IDLE;
                    grant_d         = '0;
                    err_d[owner_q]  = 1'b1;
                    rr_d            = owner_q;
                    terr_d          = 1'b1;
                end
            end
            StRun: begin
                // Watchdog keeps running across the ack so it bounds the whole job.
                wdog_d = wdog_q + 1'b1;
                if (bus.enc_stop == ENC_DONE) begin
                    state_d         = StIdle;
                    grant_d         = '0;
                    done_d[owner_q] = 1'b1;
                    jobs_d          = jobs_q + 16'd1;
                    rr_d            = owner_q;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d         = StErr;
                    enc_start_d     = ENC_IDLE;
                    grant_d         = '0;
                    err_d[owner_q]  = 1'b1;
                    rr_d            = owner_q;
                    terr_d          = 1'b1;
                end
            end
            StErr: begin
                if (bus.err_clr) begin
                    state_d = StIdle;
                    terr_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers, cleared asynchronously by the shared reset net.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            enc_start_q <= ENC_IDLE;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            jobs_q      <= '0;
            wdog_q      <= '0;
            rr_q        <= PW'(NREQ - 1);
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            enc_start_q <= enc_start_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            jobs_q      <= jobs_d;
            wdog_q      <= wdog_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done_pulse  = done_q;
    assign bus.err_pulse   = err_q;
    assign bus.enc_start   = enc_start_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.jobs_done   = jobs_q;
endmodule
